// File: rtl/psram_stream_reader.sv
// Streams word_count consecutive PSRAM words from start_addr into a small FIFO
// that feeds a valid/ready consumer; at most one controller read is in flight.
module psram_stream_reader #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [21:0]      start_addr_i,
    input  logic [LEN_W-1:0] word_count_i,
    input  logic             abort_i,
    output logic             active_o,
    output logic             done_o,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    input  logic             out_ready_i,
    output logic             word_rd_o,
    output logic             word_wr_o,
    output logic [21:0]      word_addr_o,
    output logic [31:0]      word_data_o,
    output logic [3:0]       word_wstrb_o,
    input  logic             word_busy_i,
    input  logic [31:0]      word_q_i,
    input  logic             word_q_valid_i,
    output logic [1:0]       state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic             active_q;
    logic             done_q;
    logic             word_rd_q;
    logic [21:0]      word_addr_q;
    logic [21:0]      cur_addr_q;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] pending_q;
    logic             outstanding_q;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] fifo_count_q;
    logic [CNT_W-1:0] fifo_count_d;

    logic             pop;
    logic             push;
    logic             issue;
    logic             start_job;
    logic             fifo_clr;
    logic [CNT_W:0]   occ_after;
    logic             unused_busy;

    // Controller busy is informational only; sequencing relies on word_q_valid.
    assign unused_busy = word_busy_i;

    // Stream handshake: out_valid_o is high whenever the FIFO holds a word and
    // out_data_o is that word; a transfer happens on any cycle where
    // out_valid_o & out_ready_i, and out_data_o advances on the next edge.
    assign pop  = (fifo_count_q != '0) && out_ready_i;
    assign push = (state_q == S_RUN) && !abort_i && outstanding_q && word_q_valid_i;

    // Credit: the returning word is counted as already occupying a slot.
    assign occ_after = {1'b0, fifo_count_q} + {{CNT_W{1'b0}}, word_q_valid_i};

    assign issue = (state_q == S_RUN) && !abort_i && (remaining_q != '0)
                   && (!outstanding_q || word_q_valid_i) && !word_rd_q
                   && (occ_after < (CNT_W+1)'(FIFO_DEPTH));

    assign start_job = (state_q == S_IDLE) && start_i && !abort_i && (word_count_i != '0);

    assign fifo_clr = ((state_q == S_IDLE) && abort_i) || start_job
                      || ((state_q == S_RUN) && abort_i)
                      || ((state_q == S_FLUSH) && word_q_valid_i);

    assign fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word_q_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_count_q <= fifo_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
            word_rd_q     <= 1'b0;
            word_addr_q   <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            pending_q     <= '0;
            outstanding_q <= 1'b0;
        end else begin
            word_rd_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!abort_i && start_i) begin
                        if (word_count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // First read goes out straight from the start cycle.
                            state_q       <= S_RUN;
                            active_q      <= 1'b1;
                            word_rd_q     <= 1'b1;
                            word_addr_q   <= start_addr_i;
                            cur_addr_q    <= start_addr_i + 22'd1;
                            remaining_q   <= word_count_i - LEN_W'(1);
                            pending_q     <= word_count_i;
                            outstanding_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        if (outstanding_q && !word_q_valid_i) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q       <= S_IDLE;
                            active_q      <= 1'b0;
                            outstanding_q <= 1'b0;
                        end
                    end else begin
                        if (push) begin
                            pending_q <= pending_q - LEN_W'(1);
                            if (pending_q == LEN_W'(1)) begin
                                done_q   <= 1'b1;
                                active_q <= 1'b0;
                                state_q  <= S_IDLE;
                            end
                        end
                        if (issue) begin
                            word_rd_q     <= 1'b1;
                            word_addr_q   <= cur_addr_q;
                            cur_addr_q    <= cur_addr_q + 22'd1;
                            remaining_q   <= remaining_q - LEN_W'(1);
                            outstanding_q <= 1'b1;
                        end else if (push) begin
                            outstanding_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (word_q_valid_i) begin
                        state_q       <= S_IDLE;
                        active_q      <= 1'b0;
                        outstanding_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign active_o     = active_q;
    assign done_o       = done_q;
    assign word_rd_o    = word_rd_q;
    assign word_addr_o  = word_addr_q;
    assign word_wr_o    = 1'b0;
    assign word_data_o  = 32'd0;
    assign word_wstrb_o = 4'b0000;
    assign out_valid_o  = (fifo_count_q != '0);
    assign out_data_o   = mem_q[rd_ptr_q];
    assign state_o      = state_q;

endmodule

// File: tb/tb_psram_stream_reader.sv
// Bench for psram_stream_reader: behavioural PSRAM controller, read-address and
// stream-data scoreboards, directed job scenarios.
module tb_psram_stream_reader;

    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [21:0] start_addr;
    logic [15:0] word_count;
    logic        abort;
    logic        active;
    logic        done;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        word_rd;
    logic        word_wr;
    logic [21:0] word_addr;
    logic [31:0] word_data;
    logic [3:0]  word_wstrb;
    logic        word_busy;
    logic [31:0] word_q;
    logic        word_q_valid;
    logic [1:0]  state;

    psram_stream_reader #(.FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_i(start), .start_addr_i(start_addr), .word_count_i(word_count), .abort_i(abort),
        .active_o(active), .done_o(done), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ready_i(out_ready),
        .word_rd_o(word_rd), .word_wr_o(word_wr), .word_addr_o(word_addr),
        .word_data_o(word_data), .word_wstrb_o(word_wstrb),
        .word_busy_i(word_busy), .word_q_i(word_q), .word_q_valid_i(word_q_valid),
        .state_o(state)
    );

    logic [31:0] exp_q[$];
    logic [21:0] exp_addr_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    int drop_base = 0;
    int rd0, dn0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [21:0] a);
        return {10'h2B3, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [21:0] a);
        exp_addr_q.push_back(a);
        exp_q.push_back(data_of(a));
    endtask

    task automatic start_job(input logic [21:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((active || out_valid || exp_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Behavioural controller: fixed latency, data derived from the address.
    initial begin
        logic [21:0] m_addr;
        logic        m_kill;
        word_q_valid = 1'b0; word_q = '0; word_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (word_rd && reset_n) begin
                m_addr = word_addr;
                word_busy = 1'b1;
                m_kill = 1'b0;
                for (int i = 0; i < LAT; i++) begin
                    @(posedge clk);
                    if (!reset_n) m_kill = 1'b1;
                end
                #1;
                if (!m_kill && reset_n) begin
                    word_q_valid = 1'b1;
                    word_q = data_of(m_addr);
                end
                word_busy = 1'b0;
                @(posedge clk); #1;
                word_q_valid = 1'b0;
            end
        end
    end

    // Read-request monitor: address order and single-outstanding protocol.
    initial begin
        logic prev_rd = 1'b0;
        logic tb_out = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_rd = 1'b0; tb_out = 1'b0;
            end else begin
                if (word_rd && (prev_rd || tb_out)) begin
                    err_cnt++;
                    $display("FAIL rd_protocol: read at 0x%0h while busy", word_addr);
                end
                if (word_q_valid) tb_out = 1'b0;
                if (word_rd) begin
                    rd_cnt++;
                    tb_out = 1'b1;
                    if (exp_addr_q.size() == 0) begin
                        check("rd_unexpected", {10'd0, word_addr}, 32'hFFFF_FFFF);
                    end else begin
                        check("rd_addr", {10'd0, word_addr}, {10'd0, exp_addr_q.pop_front()});
                    end
                end
                prev_rd = word_rd;
                if (done) done_cnt++;
            end
        end
    end

    // Stream monitor: every accepted word must match the head of exp_q.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", out_data, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (reset_n && (rd_cnt - pop_cnt - drop_base > DEPTH)) begin
                err_cnt++;
                $display("FAIL fifo_overflow: occupancy %0d exceeds %0d", rd_cnt - pop_cnt - drop_base, DEPTH);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
        abort = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rd", {31'd0, word_rd}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", {10'd0, word_addr}, 32'd0);
        check("rst_tied", {word_wr, word_wstrb, word_data[26:0]}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: basic four-word job
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(22'h000100 + 22'(i));
        rd0 = rd_cnt; dn0 = done_cnt;
        start_job(22'h000100, 16'd4);
        check("t1_rd_latency", {31'd0, word_rd}, 32'd1);
        check("t1_first_addr", {10'd0, word_addr}, 32'h100);
        wait_drain("t1_drain", 200);
        cycles(2);
        check("t1_reads", rd_cnt - rd0, 4);
        check("t1_done", done_cnt - dn0, 1);

        // 2: credit stall with consumer blocked
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) expect_word(22'h002000 + 22'(i));
        rd0 = rd_cnt; dn0 = done_cnt;
        start_job(22'h002000, 16'd20);
        cycles(80);
        check("t2_stall_reads", rd_cnt - rd0, 8);
        check("t2_stall_valid", {31'd0, out_valid}, 32'd1);
        check("t2_stall_active", {31'd0, active}, 32'd1);
        out_ready = 1'b1;
        wait_drain("t2_drain", 400);
        cycles(2);
        check("t2_reads", rd_cnt - rd0, 20);
        check("t2_done", done_cnt - dn0, 1);

        // 3: address wrap
        expect_word(22'h3FFFFE); expect_word(22'h3FFFFF);
        expect_word(22'h000000); expect_word(22'h000001);
        rd0 = rd_cnt;
        start_job(22'h3FFFFE, 16'd4);
        wait_drain("t3_drain", 200);
        check("t3_reads", rd_cnt - rd0, 4);

        // 4: zero-length job
        rd0 = rd_cnt;
        start_job(22'h001234, 16'd0);
        check("t4_done_pulse", {31'd0, done}, 32'd1);
        check("t4_active", {31'd0, active}, 32'd0);
        cycles(1);
        check("t4_done_once", {31'd0, done}, 32'd0);
        cycles(10);
        check("t4_no_reads", rd_cnt - rd0, 0);

        // 5: abort with a read outstanding, then restart
        exp_addr_q.push_back(22'h000500);
        rd0 = rd_cnt; dn0 = done_cnt;
        start_job(22'h000500, 16'd6);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("t5_flushing", {30'd0, state}, 32'd2);
        cycles(8);
        drop_base = rd_cnt - pop_cnt;
        check("t5_active", {31'd0, active}, 32'd0);
        check("t5_empty", {31'd0, out_valid}, 32'd0);
        check("t5_no_done", done_cnt - dn0, 0);
        check("t5_reads", rd_cnt - rd0, 1);
        expect_word(22'h000600); expect_word(22'h000601);
        start_job(22'h000600, 16'd2);
        wait_drain("t5_restart", 200);

        // 5b: abort while stalled (nothing outstanding)
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_addr_q.push_back(22'h000900 + 22'(i));
        start_job(22'h000900, 16'd20);
        cycles(80);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        drop_base = rd_cnt - pop_cnt;
        check("t5b_active", {31'd0, active}, 32'd0);
        check("t5b_empty", {31'd0, out_valid}, 32'd0);
        check("t5b_state", {30'd0, state}, 32'd0);
        out_ready = 1'b1;

        // 6: start while active is ignored
        for (int i = 0; i < 6; i++) expect_word(22'h000700 + 22'(i));
        rd0 = rd_cnt; dn0 = done_cnt;
        start_job(22'h000700, 16'd6);
        cycles(2);
        start = 1'b1; start_addr = 22'h007777; word_count = 16'd3;
        cycles(1);
        start = 1'b0;
        wait_drain("t6_drain", 200);
        cycles(2);
        check("t6_reads", rd_cnt - rd0, 6);
        check("t6_done", done_cnt - dn0, 1);

        // 6b: reset mid-job while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) expect_word(22'h000A00 + 22'(i));
        start_job(22'h000A00, 16'd10);
        cycles(80);
        reset_n = 1'b0;
        #2;
        check("t6r_active", {31'd0, active}, 32'd0);
        check("t6r_valid", {31'd0, out_valid}, 32'd0);
        check("t6r_data", out_data, 32'd0);
        check("t6r_addr", {10'd0, word_addr}, 32'd0);
        check("t6r_state", {30'd0, state}, 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        drop_base = rd_cnt - pop_cnt;
        cycles(2);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_word(22'h000B00 + 22'(i));
        start_job(22'h000B00, 16'd3);
        wait_drain("t6r_restart", 200);

        cycles(4);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
